mem_access_unit: RTL and testbench

Sequencer between the 8-bit CPU control unit and the `memory` block, and the sole driver of its `address`, `write` and `data_in`. Owns the program counter. Serialises instruction fetches, operand loads and stores into correctly timed single-port bus cycles. Accounts for the one-cycle read latency of the synchronous ROM/RW arrays and returns each read byte to the control unit with a one-cycle valid pulse.

---
 rtl/mem_access_unit.sv | 124 ++++++++++++
 tb/tb_mem_access_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Bus sequencer between the CPU control unit and memory; owns the PC.
// Define MAU_STORE_CHECK_EN to reject stores to ROM and input-port space.
module mem_access_unit #(
    parameter logic [7:0] PC_RESET = 8'h00,
    parameter logic [7:0] ROM_TOP  = 8'h7F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_req,
    input  logic       load_req,
    input  logic       store_req,
    input  logic       pc_load,
    input  logic [7:0] pc_value,
    input  logic [7:0] op_addr,
    input  logic [7:0] op_data,
    output logic       busy,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_is_fetch,
    output logic [7:0] pc,
    output logic       fault,
    output logic [7:0] mem_address,
    output logic       mem_write,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RADDR = 2'd1,
        RDATA = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t     state_q;
    logic [7:0] pc_q;
    logic [7:0] pc_d;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic       write_q;
    logic       rd_fetch_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;
    logic       rsp_fetch_q;
    logic       fault_q;
    logic       store_ok;

    assign pc_d = (pc_q == ROM_TOP) ? 8'h00 : pc_q + 8'h01;

`ifdef MAU_STORE_CHECK_EN
    // ROM below 0x80 and input ports at 0xE0..0xEF are not writable
    assign store_ok = !((op_addr < 8'h80) || (op_addr[7:4] == 4'hE));
`else
    assign store_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= PC_RESET;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            write_q     <= 1'b0;
            rd_fetch_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_fetch_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pc_load) begin
                        pc_q <= pc_value;
                    end else if (store_req) begin
                        if (store_ok) begin
                            addr_q  <= op_addr;
                            wdata_q <= op_data;
                            write_q <= 1'b1;
                            state_q <= WRITE;
                        end else begin
                            fault_q <= 1'b1;
                        end
                    end else if (load_req) begin
                        addr_q     <= op_addr;
                        rd_fetch_q <= 1'b0;
                        state_q    <= RADDR;
                    end else if (fetch_req) begin
                        addr_q     <= pc_q;
                        pc_q       <= pc_d;
                        rd_fetch_q <= 1'b1;
                        state_q    <= RADDR;
                    end
                end
                // memory captures the address at the end of this cycle
                RADDR: begin
                    state_q <= RDATA;
                end
                RDATA: begin
                    rsp_data_q  <= mem_rdata;
                    rsp_valid_q <= 1'b1;
                    rsp_fetch_q <= rd_fetch_q;
                    state_q     <= IDLE;
                end
                WRITE: begin
                    write_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_is_fetch = rsp_fetch_q;
    assign pc           = pc_q;
    assign fault        = fault_q;
    assign mem_address  = addr_q;
    assign mem_write    = write_q;
    assign mem_wdata    = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus random bench for mem_access_unit against a byte-array model.
// Honours MAU_STORE_CHECK_EN when the design is built with it.
module tb_mem_access_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fetch_req = 1'b0;
    logic       load_req = 1'b0;
    logic       store_req = 1'b0;
    logic       pc_load = 1'b0;
    logic [7:0] pc_value = 8'h00;
    logic [7:0] op_addr = 8'h00;
    logic [7:0] op_data = 8'h00;
    logic       busy;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_is_fetch;
    logic [7:0] pc;
    logic       fault;
    logic [7:0] mem_address;
    logic       mem_write;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] m_pc;
    logic [7:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_rsp;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .load_req(load_req),
        .store_req(store_req), .pc_load(pc_load),
        .pc_value(pc_value), .op_addr(op_addr), .op_data(op_data),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_is_fetch(rsp_is_fetch), .pc(pc), .fault(fault),
        .mem_address(mem_address), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // synchronous single-port memory with one-cycle read latency
    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_wdata;
        mem_rdata <= mem[mem_address];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit store_legal(input logic [7:0] a);
`ifdef MAU_STORE_CHECK_EN
        return !(a < 8'h80 || (a >= 8'hE0 && a <= 8'hEF));
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk_reset_vals();
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'h00);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_is_fetch", {7'd0, rsp_is_fetch}, 8'h00);
        chk("rst_pc", pc, 8'h00);
        chk("rst_fault", {7'd0, fault}, 8'h00);
        chk("rst_mem_address", mem_address, 8'h00);
        chk("rst_mem_write", {7'd0, mem_write}, 8'h00);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
    endtask

    // called one step after the accepting edge
    task automatic wait_rsp(input bit is_f, input logic [7:0] ea);
        int n;
        n = 0;
        while (!rsp_valid && n < 6) begin
            tick();
            n++;
        end
        chk("rd_latency", 8'(n), 8'd2);
        chk("rsp_valid", {7'd0, rsp_valid}, 8'h01);
        chk("rsp_data", rsp_data, ref_mem[ea]);
        chk("rsp_is_fetch", {7'd0, rsp_is_fetch}, {7'd0, is_f});
        chk("rsp_busy", {7'd0, busy}, 8'h00);
        m_rsp = ref_mem[ea];
        tick();
        chk("rsp_pulse", {7'd0, rsp_valid}, 8'h00);
        chk("rsp_hold", rsp_data, m_rsp);
    endtask

    task automatic do_read(input bit is_f, input logic [7:0] a);
        logic [7:0] ea;
        ea = is_f ? m_pc : a;
        if (is_f) fetch_req = 1'b1;
        else begin
            load_req = 1'b1;
            op_addr = a;
        end
        tick();
        fetch_req = 1'b0;
        load_req = 1'b0;
        if (is_f) m_pc = (m_pc == 8'h7F) ? 8'h00 : m_pc + 8'h01;
        m_addr = ea;
        chk("acc_busy", {7'd0, busy}, 8'h01);
        chk("acc_addr", mem_address, ea);
        chk("acc_pc", pc, m_pc);
        wait_rsp(is_f, ea);
    endtask

    task automatic do_store(input logic [7:0] a, input logic [7:0] d);
        store_req = 1'b1;
        op_addr = a;
        op_data = d;
        tick();
        store_req = 1'b0;
        if (store_legal(a)) begin
            m_addr = a;
            m_wdata = d;
            ref_mem[a] = d;
            chk("st_write", {7'd0, mem_write}, 8'h01);
            chk("st_busy", {7'd0, busy}, 8'h01);
            chk("st_addr", mem_address, a);
            chk("st_wdata", mem_wdata, d);
            chk("st_fault", {7'd0, fault}, 8'h00);
        end else begin
            chk("ill_fault", {7'd0, fault}, 8'h01);
            chk("ill_write", {7'd0, mem_write}, 8'h00);
            chk("ill_busy", {7'd0, busy}, 8'h00);
            chk("ill_addr", mem_address, m_addr);
            chk("ill_wdata", mem_wdata, m_wdata);
        end
        tick();
        chk("st_write_end", {7'd0, mem_write}, 8'h00);
        chk("st_busy_end", {7'd0, busy}, 8'h00);
        chk("st_fault_end", {7'd0, fault}, 8'h00);
    endtask

    task automatic do_pcload(input logic [7:0] v);
        pc_load = 1'b1;
        pc_value = v;
        tick();
        pc_load = 1'b0;
        m_pc = v;
        chk("pcl_pc", pc, v);
        chk("pcl_busy", {7'd0, busy}, 8'h00);
        chk("pcl_write", {7'd0, mem_write}, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[0] = 8'hA5;
        ref_mem[0] = 8'hA5;
        m_pc = 8'h00;
        m_addr = 8'h00;
        m_wdata = 8'h00;
        m_rsp = 8'h00;

        reset = 1'b1;
        tick();
        tick();
        chk_reset_vals();
        reset = 1'b0;

        do_read(1'b1, 8'h00);
        do_pcload(8'h7F);
        do_read(1'b1, 8'h00);
        do_store(8'h90, 8'h3C);
        do_read(1'b0, 8'h90);

        // pc_load beats store beats fetch
        pc_load = 1'b1;
        pc_value = 8'h20;
        store_req = 1'b1;
        op_addr = 8'hA0;
        op_data = 8'h5A;
        fetch_req = 1'b1;
        tick();
        pc_load = 1'b0;
        m_pc = 8'h20;
        chk("pri_pc", pc, 8'h20);
        chk("pri_busy0", {7'd0, busy}, 8'h00);
        tick();
        store_req = 1'b0;
        ref_mem[8'hA0] = 8'h5A;
        m_addr = 8'hA0;
        m_wdata = 8'h5A;
        chk("pri_st_busy", {7'd0, busy}, 8'h01);
        chk("pri_st_write", {7'd0, mem_write}, 8'h01);
        chk("pri_st_addr", mem_address, 8'hA0);
        tick();
        chk("pri_st_done", {7'd0, busy}, 8'h00);
        tick();
        fetch_req = 1'b0;
        m_pc = 8'h21;
        m_addr = 8'h20;
        chk("pri_f_addr", mem_address, 8'h20);
        chk("pri_f_pc", pc, 8'h21);
        wait_rsp(1'b1, 8'h20);

        // reset while the load sits in RDATA
        op_addr = 8'h90;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals();
        m_pc = 8'h00;
        m_addr = 8'h00;
        m_wdata = 8'h00;
        m_rsp = 8'h00;
        tick();
        chk("rst_no_rsp", {7'd0, rsp_valid}, 8'h00);

        do_pcload(8'hFF);
        do_read(1'b1, 8'h00);
        chk("wrap_ff_pc", pc, 8'h00);

        do_store(8'h10, 8'h77);
        do_store(8'hE3, 8'h88);
        do_store(8'hF0, 8'h99);
        do_read(1'b0, 8'hF0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: do_read(1'b1, 8'h00);
                1: do_read(1'b0, 8'($urandom));
                2: do_store(8'($urandom), 8'($urandom));
                default: do_pcload(8'($urandom_range(0, 127)));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
